// File: rtl/image_place.sv
// image_place: scans a fixed video raster and fills a latched rectangular window with
// pixels from a FWFT FIFO. Define IMAGE_PLACE_UNDERFLOW_FLAG_EN to build the sticky underflow flag.
module image_place #(
    parameter int          H_DISP     = 1920,
    parameter int          H_FP       = 88,
    parameter int          H_SYNC     = 44,
    parameter int          H_BP       = 148,
    parameter int          V_DISP     = 1080,
    parameter int          V_FP       = 4,
    parameter int          V_SYNC     = 5,
    parameter int          V_BP       = 36,
    parameter logic [23:0] BORDER_RGB = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [10:0] start_x,
    input  logic [10:0] start_y,
    input  logic [10:0] end_x,
    input  logic [10:0] end_y,
    input  logic        fifo_empty,
    input  logic [23:0] fifo_data,
    output logic        fifo_rd,
    output logic        hs_o,
    output logic        vs_o,
    output logic        de_o,
    output logic [23:0] rgb_o,
    output logic        underflow
);
    localparam logic [11:0] H_LAST = 12'(H_DISP + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_LAST = 12'(V_DISP + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] H_ACT  = 12'(H_DISP);
    localparam logic [11:0] V_ACT  = 12'(V_DISP);
    localparam logic [11:0] HS_BEG = 12'(H_DISP + H_FP);
    localparam logic [11:0] HS_END = 12'(H_DISP + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG = 12'(V_DISP + V_FP);
    localparam logic [11:0] VS_END = 12'(V_DISP + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t      state_q;
    logic [11:0] h_cnt_q, v_cnt_q;
    logic [10:0] sx_q, sy_q, ex_q, ey_q;
    logic        de_q, hs_q, vs_q;
    logic [23:0] rgb_q;

    logic        running, frame_start, h_last, v_last;
    logic        in_active, in_window, win_pix;
    logic [10:0] sx_w, sy_w, ex_w, ey_w;
    logic        de_d, hs_d, vs_d;
    logic [23:0] rgb_d;

    // On the first cycle of every frame the live window inputs are used directly,
    // so the registers latched on that same cycle never lag the pixel at (0,0).
    always_comb begin
        running     = (state_q == ACTIVE);
        frame_start = running && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        sx_w        = frame_start ? start_x : sx_q;
        sy_w        = frame_start ? start_y : sy_q;
        ex_w        = frame_start ? end_x   : ex_q;
        ey_w        = frame_start ? end_y   : ey_q;
        h_last      = (h_cnt_q == H_LAST);
        v_last      = (v_cnt_q == V_LAST);
        in_active   = running && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        in_window   = (h_cnt_q >= {1'b0, sx_w}) && (h_cnt_q < {1'b0, ex_w}) &&
                      (v_cnt_q >= {1'b0, sy_w}) && (v_cnt_q < {1'b0, ey_w});
        win_pix     = in_active && in_window;
        fifo_rd     = win_pix && !fifo_empty && !rst;
        de_d        = in_active;
        hs_d        = running && (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
        vs_d        = running && (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
        rgb_d       = '0;
        if (fifo_rd) begin
            rgb_d = fifo_data;
        end else if (in_active) begin
            rgb_d = BORDER_RGB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            ex_q    <= '0;
            ey_q    <= '0;
            de_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            rgb_q <= rgb_d;
            if (frame_start) begin
                sx_q <= start_x;
                sy_q <= start_y;
                ex_q <= end_x;
                ey_q <= end_y;
            end
            case (state_q)
                IDLE: begin
                    if (en) state_q <= ARMED;
                end
                ARMED: begin
                    if (!en) begin
                        state_q <= IDLE;
                    end else if (!fifo_empty) begin
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // Raster never stalls: FIFO state only affects pixel content.
                    if (h_last) begin
                        h_cnt_q <= '0;
                        if (v_last) begin
                            v_cnt_q <= '0;
                            if (!en) state_q <= IDLE;
                        end else begin
                            v_cnt_q <= v_cnt_q + 12'd1;
                        end
                    end else begin
                        h_cnt_q <= h_cnt_q + 12'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign de_o  = de_q;
    assign hs_o  = hs_q;
    assign vs_o  = vs_q;
    assign rgb_o = rgb_q;

`ifdef IMAGE_PLACE_UNDERFLOW_FLAG_EN
    logic underflow_q;
    logic uf_evt;

    assign uf_evt = win_pix && fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_q <= 1'b0;
        end else if (uf_evt) begin
            underflow_q <= 1'b1;
        end
    end

    assign underflow = underflow_q;
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_image_place.sv
// Bench for image_place on a 14x7 raster: a per-cycle scoreboard of {de,hs,vs,underflow,rgb}
// aligned on the first de_o of each run, plus direct checks around reset and FIFO pops.
module tb_image_place;
    localparam logic [23:0] BORDER = 24'h0000FF;
`ifdef IMAGE_PLACE_UNDERFLOW_FLAG_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en;
    logic [10:0] start_x, start_y, end_x, end_y;
    logic        fifo_empty;
    logic [23:0] fifo_data;
    logic        fifo_rd, hs_o, vs_o, de_o, underflow;
    logic [23:0] rgb_o;

    always #5 clk = ~clk;

    image_place #(
        .H_DISP(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .BORDER_RGB(24'h0000FF)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .start_x(start_x), .start_y(start_y), .end_x(end_x), .end_y(end_y),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
        .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .rgb_o(rgb_o), .underflow(underflow)
    );

    logic [27:0] exp_q[$];
    logic [23:0] fq[$];
    logic [23:0] model_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int pop_cnt = 0;
    bit mon_on   = 1'b0;
    bit uf_model = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic refresh_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_data  = fifo_empty ? 24'h0 : fq[0];
    endtask

    task automatic load_fifo(input int n, input logic [23:0] base);
        for (int i = 0; i < n; i++) begin
            fq.push_back(base + 24'(i));
            model_q.push_back(base + 24'(i));
        end
        refresh_fifo();
    endtask

    // Reference raster: hsync at h 10-11, vsync on line 5, active area 8x4.
    task automatic push_frame(input int sx, input int sy, input int ex, input int ey);
        for (int v = 0; v < 7; v++) begin
            for (int h = 0; h < 14; h++) begin
                logic de, hs, vs, win;
                logic [23:0] px;
                de  = (h < 8) && (v < 4);
                hs  = (h >= 10) && (h < 12);
                vs  = (v == 5);
                win = de && (h >= sx) && (h < ex) && (v >= sy) && (v < ey);
                px  = 24'h0;
                if (win && model_q.size() > 0) begin
                    px = model_q.pop_front();
                end else if (de) begin
                    px = BORDER;
                    if (win && UF_EN) uf_model = 1'b1;
                end
                exp_q.push_back({de, hs, vs, uf_model, px});
            end
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({3'b000, uf_model, 24'h0});
    endtask

    task automatic run_monitor();
        logic [27:0] want, got;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0 && (mon_on || de_o === 1'b1)) begin
                mon_on = 1'b1;
                want = exp_q.pop_front();
                got  = {de_o, hs_o, vs_o, underflow, rgb_o};
                check("frame_px", 32'(got), 32'(want));
                if (exp_q.size() == 0) mon_on = 1'b0;
            end
        end
    endtask

    task automatic run_fifo();
        logic rd;
        forever begin
            @(negedge clk);
            rd = fifo_rd;
            @(posedge clk);
            if (rd) begin
                #1;
                if (fq.size() != 0) void'(fq.pop_front());
                pop_cnt++;
                refresh_fifo();
            end
        end
    endtask

    task automatic wait_started(input string name);
        int n;
        n = 0;
        while (!mon_on && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_started"}, 32'(mon_on), 32'd1);
        tick(1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        mon_on = 1'b0;
        tick(1);
    endtask

    // Runs nframes frames; the window's end_x becomes ex2 shortly after the first frame starts.
    task automatic run_test(input string name, input int sx, input int sy, input int ex,
                            input int ey, input int ex2, input int nwords,
                            input logic [23:0] base, input int nframes, input int pops_exp);
        int p0;
        load_fifo(nwords, base);
        start_x = 11'(sx);
        start_y = 11'(sy);
        end_x   = 11'(ex);
        end_y   = 11'(ey);
        for (int f = 0; f < nframes; f++) push_frame(sx, sy, (f == 0) ? ex : ex2, ey);
        push_idle(4);
        p0 = pop_cnt;
        en = 1'b1;
        wait_started(name);
        tick(10);
        end_x = 11'(ex2);
        tick(98 * (nframes - 1));
        en = 1'b0;
        wait_drain(name);
        check({name, "_pops"}, pop_cnt - p0, pops_exp);
        check({name, "_fifo_left"}, fq.size(), nwords - pops_exp);
    endtask

    initial begin
        int pc, fs, n;
        rst = 1'b1;
        en  = 1'b1;
        start_x = '0; start_y = '0; end_x = '0; end_y = '0;
        refresh_fifo();
        fork
            run_monitor();
            run_fifo();
            begin
                #200000;
                $display("FAIL watchdog: simulation did not finish in time");
                $fatal(1);
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {de_o, hs_o, vs_o, underflow, rgb_o}, 0);
        check("reset_fifo_rd", fifo_rd, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b0;
        tick(3);

        run_test("full_win",    0, 0, 8, 4, 8, 32, 24'h000000, 1, 32);
        run_test("small_win",   2, 1, 5, 3, 5, 12, 24'hB00000, 2, 12);
        run_test("midframe_ex", 2, 0, 6, 4, 2, 16, 24'hD00000, 2, 16);
        run_test("underrun",    0, 0, 8, 4, 8,  3, 24'hC00000, 2,  3);
        @(negedge clk);
        check("uf_after_underrun", underflow, 32'(UF_EN));
        tick(1);

        load_fifo(20, 24'hE00000);
        start_x = 11'd0; start_y = 11'd0; end_x = 11'd8; end_y = 11'd4;
        en = 1'b1;
        n = 0;
        while (de_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_started", de_o, 1);
        tick(3);
        rst = 1'b1;
        @(negedge clk);
        pc = pop_cnt;
        fs = fq.size();
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b0;
        uf_model = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", {de_o, hs_o, vs_o, underflow, rgb_o}, 0);
        check("rst_mid_no_pop", pop_cnt, pc);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("idle_after_rst", {hs_o, vs_o, de_o, fifo_rd}, 0);
        end
        check("rst_fifo_untouched", fq.size(), fs);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
